ifm_stream_feeder: RTL and testbench

//  Source end of the CNN input-feature-map read interface: holds one input frame (CI x IFM_SIZE x IFM_SIZE words)

---
 rtl/cnn_feeder_pkg.sv | 15 +
 rtl/ifm_frame_buf.sv | 23 ++
 rtl/ifm_stream_feeder.sv | 118 +++++++++++
 tb/tb_ifm_stream_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_feeder_pkg.sv
// Shared types and sizing helpers for the CNN input-feature-map feeder.
package cnn_feeder_pkg;

  typedef enum logic [1:0] {StIdle, StKick, StServe, StDone} feeder_state_e;

  function automatic int unsigned calc_frame_words(input int unsigned ci,
                                                   input int unsigned size);
    return ci * size * size;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ifm_frame_buf.sv
// Frame buffer: one write port, one registered read port; maps onto block RAM.
module ifm_frame_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2187,
  parameter int unsigned AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ifm_stream_feeder.sv
// Holds one input frame, kicks the first conv layer and serves one word per ifm_read.
// Optional IFM_FEEDER_CHECKSUM_EN adds a running sum of served words on a checksum port.
module ifm_stream_feeder
  import cnn_feeder_pkg::*;
#(
  parameter int unsigned IFM_WIDTH = 16,
  parameter int unsigned IFM_SIZE  = 27,
  parameter int unsigned CI        = 3,
  localparam int unsigned FRAME_WORDS = calc_frame_words(CI, IFM_SIZE),
  localparam int unsigned ADDR_W      = calc_addr_w(FRAME_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [IFM_WIDTH-1:0] wr_data,
  input  logic                 start,
  input  logic                 ifm_read,
  output logic [IFM_WIDTH-1:0] ifm,
  output logic                 start_conv,
  output logic                 busy,
  output logic                 done,
  output logic                 overread
`ifdef IFM_FEEDER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  feeder_state_e state_q, state_d;

  logic [ADDR_W-1:0]    rd_ptr_q;
  logic                 zero_q;
  logic                 overread_q;
  logic [IFM_WIDTH-1:0] ram_q;
  logic                 rd_accept, wr_accept, start_accept, last_word;

  assign rd_accept    = (state_q == StServe) && ifm_read;
  assign start_accept = (state_q == StIdle) && start;
  assign wr_accept    = (state_q == StIdle) && wr_en && (32'(wr_addr) < FRAME_WORDS);
  assign last_word    = (rd_ptr_q == ADDR_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StKick;
      StKick:  state_d = StServe;
      StServe: if (ifm_read && last_word) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_conv = (state_q == StKick);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  // zero_q forces ifm to 0 after reset or a stray read without clearing the RAM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      zero_q     <= 1'b1;
      overread_q <= 1'b0;
    end else begin
      if (start_accept)   rd_ptr_q <= '0;
      else if (rd_accept) rd_ptr_q <= rd_ptr_q + 1'b1;

      if (rd_accept)     zero_q <= 1'b0;
      else if (ifm_read) zero_q <= 1'b1;

      if (ifm_read && (state_q != StServe)) overread_q <= 1'b1;
      else if (start_accept)                overread_q <= 1'b0;
    end
  end

  assign ifm      = zero_q ? '0 : ram_q;
  assign overread = overread_q;

  ifm_frame_buf #(
    .WIDTH (IFM_WIDTH),
    .DEPTH (FRAME_WORDS),
    .AW    (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (ram_q)
  );

`ifdef IFM_FEEDER_CHECKSUM_EN
  // A word counts once its RAM read has landed, one cycle after the accepted strobe.
  logic rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      checksum   <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (start_accept)    checksum <= '0;
      else if (rd_valid_q) checksum <= checksum + 32'(ram_q);
    end
  end
`else
  // Default build carries no checksum path.
`endif

endmodule

// File: tb/tb_ifm_stream_feeder.sv
// Directed bench for ifm_stream_feeder: reset, full/gapped frames, overread, write lockout, restart.
module tb_ifm_stream_feeder;

  localparam int unsigned FRAME_WORDS = 2187;
  localparam int unsigned ADDR_W      = 12;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, ifm_read;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] ifm;
  logic        start_conv, busy, done, overread;
`ifdef IFM_FEEDER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int   checks = 0;
  int   errors = 0;
  logic all_ones = 1'b0;

  always #5 clk = ~clk;

  ifm_stream_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .ifm_read   (ifm_read),
    .ifm        (ifm),
    .start_conv (start_conv),
    .busy       (busy),
    .done       (done),
    .overread   (overread)
`ifdef IFM_FEEDER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return all_ones ? 32'h0000_FFFF : 32'(i);
  endfunction

  task automatic load_frame();
    for (int i = 0; i < int'(FRAME_WORDS); i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = all_ones ? 16'hFFFF : 16'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // gap = idle cycles between strobes; checks ifm holds through each gap.
  task automatic serve_frame(input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("kick_start_conv", {31'b0, start_conv}, 32'd1);
    chk("kick_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("serve_start_conv", {31'b0, start_conv}, 32'd0);
    for (int i = 0; i < int'(FRAME_WORDS); i++) begin
      ifm_read = 1'b1;
      tick();
      ifm_read = 1'b0;
      chk($sformatf("word%0d", i), {16'b0, ifm}, exp_word(i));
      chk($sformatf("done_at%0d", i), {31'b0, done}, (i == int'(FRAME_WORDS) - 1) ? 32'd1 : 32'd0);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk($sformatf("hold%0d", i), {16'b0, ifm}, exp_word(i));
      end
    end
    tick();
    chk("end_busy", {31'b0, busy}, 32'd0);
    chk("end_done", {31'b0, done}, 32'd0);
    chk("end_overread", {31'b0, overread}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start    = 1'b0;
    ifm_read = 1'b1;
    repeat (3) tick();
    chk("rst_ifm", {16'b0, ifm}, 32'd0);
    chk("rst_start_conv", {31'b0, start_conv}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_overread", {31'b0, overread}, 32'd0);
`ifdef IFM_FEEDER_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif
    ifm_read = 1'b0;
    rst      = 1'b0;
    tick();

    load_frame();
    serve_frame(0);
`ifdef IFM_FEEDER_CHECKSUM_EN
    chk("checksum_ramp", checksum, 32'd2390391);
`endif
    serve_frame(2);

    // Stray read in IDLE.
    ifm_read = 1'b1;
    tick();
    ifm_read = 1'b0;
    chk("or_set", {31'b0, overread}, 32'd1);
    chk("or_ifm", {16'b0, ifm}, 32'd0);
    chk("or_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("or_sticky", {31'b0, overread}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("or_clear", {31'b0, overread}, 32'd0);
    chk("or_kick", {31'b0, start_conv}, 32'd1);
    tick();
    ifm_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("replay%0d", i), {16'b0, ifm}, 32'(i));
    end
    // Write and start while busy must both be ignored.
    ifm_read = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = 12'd5;
    wr_data  = 16'hBEEF;
    start    = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("lock_busy", {31'b0, busy}, 32'd1);
    chk("lock_hold", {16'b0, ifm}, 32'd3);
    ifm_read = 1'b1;
    tick();
    chk("lock_word4", {16'b0, ifm}, 32'd4);
    tick();
    chk("lock_word5", {16'b0, ifm}, 32'd5);
    ifm_read = 1'b0;
    chk("lock_overread", {31'b0, overread}, 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_ifm", {16'b0, ifm}, 32'd0);
    chk("midrst_start_conv", {31'b0, start_conv}, 32'd0);
    serve_frame(0);

`ifdef IFM_FEEDER_CHECKSUM_EN
    all_ones = 1'b1;
    load_frame();
    serve_frame(0);
    chk("checksum_ones", checksum, 32'd143325045);
`endif

    // Write and start in the same IDLE cycle: the write lands before streaming.
    wr_en   = 1'b1;
    wr_addr = 12'd0;
    wr_data = 16'h1234;
    start   = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("wrst_kick", {31'b0, start_conv}, 32'd1);
    tick();
    ifm_read = 1'b1;
    tick();
    chk("wrst_word0", {16'b0, ifm}, 32'h1234);
    tick();
    chk("wrst_word1", {16'b0, ifm}, exp_word(1));
    ifm_read = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
